// File: rtl/fix_conn_mgr.sv
// fix_conn_mgr -- multi-host connection manager for the FIX engine.
//
// Application connect/disconnect requests for NUM_HOSTS hosts become
// single-cycle requests towards the TOE FIFOs. Each connect attempt waits
// TIMEOUT_CYC cycles for the TOE to report the connection. The request is
// repeated up to MAX_RETRY times, and then a failure pulse is reported.
// All outputs are registered.
//
// Optional feature macro: FIX_CONN_STATS_EN (adds retry/fail statistics).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   connect_i / _to_host_i    connect request (taken only while ready_o)
//   disconnect_i / _host_i    disconnect request (taken every cycle)
//   connected_i / _host_addr_i TOE connection-established pulse + host
//   connect_req_o / _addr_o   one-cycle connect request + pending host
//   disconnect_o / _host_num_o one-cycle disconnect request + host
//   ready_o                   idle, a new connect can be accepted
//   host_up_o                 per-host connected flags
//   connect_fail_o / fail_host_o one-cycle failure pulse + host
//   retry_cnt_o, fail_cnt_o   (FIX_CONN_STATS_EN only) saturating counters
module fix_conn_mgr #(
    parameter int NUM_HOSTS   = 4,
    parameter int HOST_W      = $clog2(NUM_HOSTS),
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 connect_i,
    input  logic [HOST_W-1:0]    connect_to_host_i,
    input  logic                 disconnect_i,
    input  logic [HOST_W-1:0]    disconnect_host_i,
    input  logic                 connected_i,
    input  logic [HOST_W-1:0]    connected_host_addr_i,
    output logic                 connect_req_o,
    output logic [HOST_W-1:0]    connect_addr_o,
    output logic                 disconnect_o,
    output logic [HOST_W-1:0]    disconnect_host_num_o,
    output logic                 ready_o,
    output logic [NUM_HOSTS-1:0] host_up_o,
    output logic                 connect_fail_o,
    output logic [HOST_W-1:0]    fail_host_o
`ifdef FIX_CONN_STATS_EN
    ,
    output logic [7:0]           retry_cnt_o,
    output logic [7:0]           fail_cnt_o
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FAIL
    } state_t;

    state_t                 state_q, state_n;
    logic [TMR_W-1:0]       timer_q, timer_n;
    logic [RTY_W-1:0]       retry_q, retry_n;
    logic [HOST_W-1:0]      pending_n;
    logic [NUM_HOSTS-1:0]   host_up_n;
    logic                   conn_match;

    // connect_addr_o doubles as the pending-host register.
    assign conn_match = connected_i && (connected_host_addr_i == connect_addr_o);

    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        retry_n   = retry_q;
        pending_n = connect_addr_o;
        host_up_n = host_up_o;

        case (state_q)
            IDLE: begin
                // A disconnect of the same host in the same cycle wins.
                if (connect_i && !host_up_o[connect_to_host_i] &&
                    !(disconnect_i && (disconnect_host_i == connect_to_host_i))) begin
                    pending_n = connect_to_host_i;
                    retry_n   = '0;
                    state_n   = REQ;
                end
            end
            REQ: begin
                timer_n = '0;
                if (conn_match) begin
                    host_up_n[connect_addr_o] = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                timer_n = timer_q + 1'b1;
                if (conn_match) begin
                    host_up_n[connect_addr_o] = 1'b1;
                    state_n = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    if (retry_q < RTY_MAX) begin
                        retry_n = retry_q + 1'b1;
                        state_n = REQ;
                    end else begin
                        state_n = FAIL;
                    end
                end
            end
            FAIL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Disconnect is applied last so it overrides a same-cycle connect
        // completion and aborts an in-flight attempt for the same host.
        if (disconnect_i) begin
            host_up_n[disconnect_host_i] = 1'b0;
            if (((state_q == REQ) || (state_q == WAIT)) &&
                (disconnect_host_i == connect_addr_o)) begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= IDLE;
            timer_q               <= '0;
            retry_q               <= '0;
            connect_addr_o        <= '0;
            host_up_o             <= '0;
            ready_o               <= 1'b1;
            connect_req_o         <= 1'b0;
            disconnect_o          <= 1'b0;
            disconnect_host_num_o <= '0;
            connect_fail_o        <= 1'b0;
            fail_host_o           <= '0;
        end else begin
            state_q        <= state_n;
            timer_q        <= timer_n;
            retry_q        <= retry_n;
            connect_addr_o <= pending_n;
            host_up_o      <= host_up_n;
            ready_o        <= (state_n == IDLE);
            connect_req_o  <= (state_n == REQ);
            connect_fail_o <= (state_n == FAIL);
            if (state_n == FAIL) begin
                fail_host_o <= connect_addr_o;
            end
            disconnect_o <= disconnect_i;
            if (disconnect_i) begin
                disconnect_host_num_o <= disconnect_host_i;
            end
        end
    end

`ifdef FIX_CONN_STATS_EN
    logic retry_ev, fail_ev;

    assign retry_ev = (state_q == WAIT) && (state_n == REQ);
    assign fail_ev  = (state_n == FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt_o <= '0;
            fail_cnt_o  <= '0;
        end else begin
            if (retry_ev && (retry_cnt_o != 8'hFF)) begin
                retry_cnt_o <= retry_cnt_o + 8'd1;
            end
            if (fail_ev && (fail_cnt_o != 8'hFF)) begin
                fail_cnt_o <= fail_cnt_o + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fix_conn_mgr.sv
// Testbench for fix_conn_mgr: directed scenarios followed by randomized
// traffic. The reference model tracks each connect by the number of cycles
// elapsed since it was accepted and derives request/fail timing from that.
module tb_fix_conn_mgr;

    localparam int NH   = 4;
    localparam int HW   = 2;
    localparam int TO   = 8;
    localparam int MR   = 2;
    localparam int LAST = (MR + 1) * (TO + 1);   // elapsed count of final WAIT cycle

    logic          clk = 1'b0;
    logic          rst;
    logic          connect_i, disconnect_i, connected_i;
    logic [HW-1:0] connect_to_host_i, disconnect_host_i, connected_host_addr_i;
    logic          connect_req_o, disconnect_o, ready_o, connect_fail_o;
    logic [HW-1:0] connect_addr_o, disconnect_host_num_o, fail_host_o;
    logic [NH-1:0] host_up_o;
`ifdef FIX_CONN_STATS_EN
    logic [7:0]    retry_cnt_o, fail_cnt_o;
`endif

    fix_conn_mgr #(
        .NUM_HOSTS  (NH),
        .HOST_W     (HW),
        .TIMEOUT_CYC(TO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .connect_i            (connect_i),
        .connect_to_host_i    (connect_to_host_i),
        .disconnect_i         (disconnect_i),
        .disconnect_host_i    (disconnect_host_i),
        .connected_i          (connected_i),
        .connected_host_addr_i(connected_host_addr_i),
        .connect_req_o        (connect_req_o),
        .connect_addr_o       (connect_addr_o),
        .disconnect_o         (disconnect_o),
        .disconnect_host_num_o(disconnect_host_num_o),
        .ready_o              (ready_o),
        .host_up_o            (host_up_o),
        .connect_fail_o       (connect_fail_o),
        .fail_host_o          (fail_host_o)
`ifdef FIX_CONN_STATS_EN
        ,
        .retry_cnt_o          (retry_cnt_o),
        .fail_cnt_o           (fail_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model state: elapsed = 0 when idle, 1.. while a connect runs.
    int          m_e;
    logic [NH-1:0] m_up;
    logic [HW-1:0] m_ph, m_dnum, m_fhost;
    int          m_rcnt, m_fcnt;
    logic        x_ready, x_req, x_disc, x_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic c, input logic [HW-1:0] ch,
                         input logic d, input logic [HW-1:0] dh,
                         input logic cd, input logic [HW-1:0] cdh);
        int ne;
        if (r) begin
            m_e = 0; m_up = '0; m_ph = '0; m_dnum = '0; m_fhost = '0;
            m_rcnt = 0; m_fcnt = 0;
            x_ready = 1'b1; x_req = 1'b0; x_disc = 1'b0; x_fail = 1'b0;
        end else begin
            ne = m_e;
            if (m_e == 0) begin
                if (c && !m_up[ch] && !(d && dh == ch)) begin
                    ne = 1;
                    m_ph = ch;
                end
            end else if (m_e <= LAST) begin
                if (cd && cdh == m_ph) begin
                    m_up[m_ph] = 1'b1;
                    ne = 0;
                end else begin
                    ne = m_e + 1;
                end
            end else begin
                ne = 0;
            end
            if (d) begin
                m_up[dh] = 1'b0;
                m_dnum = dh;
                if (m_e >= 1 && m_e <= LAST && dh == m_ph) ne = 0;
            end
            x_req  = (ne >= 1) && (ne <= LAST) && ((ne - 1) % (TO + 1) == 0);
            x_fail = (ne == LAST + 1);
            if (x_fail) m_fhost = m_ph;
            if (x_req && ne > 1 && m_rcnt < 255) m_rcnt++;
            if (x_fail && m_fcnt < 255) m_fcnt++;
            x_ready = (ne == 0);
            x_disc  = d;
            m_e = ne;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic [HW-1:0] ch,
                        input logic d, input logic [HW-1:0] dh,
                        input logic cd, input logic [HW-1:0] cdh);
        @(negedge clk);
        rst = r; connect_i = c; connect_to_host_i = ch;
        disconnect_i = d; disconnect_host_i = dh;
        connected_i = cd; connected_host_addr_i = cdh;
        model(r, c, ch, d, dh, cd, cdh);
        @(posedge clk);
        #1;
        cyc++;
        check("ready",     32'(ready_o),               32'(x_ready));
        check("conn_req",  32'(connect_req_o),         32'(x_req));
        check("conn_addr", 32'(connect_addr_o),        32'(m_ph));
        check("disc",      32'(disconnect_o),          32'(x_disc));
        check("disc_host", 32'(disconnect_host_num_o), 32'(m_dnum));
        check("host_up",   32'(host_up_o),             32'(m_up));
        check("fail",      32'(connect_fail_o),        32'(x_fail));
        check("fail_host", 32'(fail_host_o),           32'(m_fhost));
`ifdef FIX_CONN_STATS_EN
        check("retry_cnt", 32'(retry_cnt_o),           32'(m_rcnt));
        check("fail_cnt",  32'(fail_cnt_o),            32'(m_fcnt));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    initial begin
        int p_conn;
        logic          r, c, d, cd;
        logic [HW-1:0] ch, dh, cdh;

        rst = 1'b1; connect_i = 1'b0; disconnect_i = 1'b0; connected_i = 1'b0;
        connect_to_host_i = '0; disconnect_host_i = '0; connected_host_addr_i = '0;

        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);

        // Connect host 2, TOE reports it at t=4.
        step(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(3);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2);
        idle(2);
        // Host 2 is up: a further connect to it is ignored.
        step(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(1);

        // Connect host 1, never answered: three requests then failure.
        step(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(31);

        // Connect host 3, answered exactly on the timeout cycle.
        step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(8);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3);
        idle(12);

        // Host 0 up, then disconnect 0 together with connect 1.
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0);
        step(1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0);
        idle(2);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1);

        // Connect host 2 (was up: disconnect first), abort during WAIT.
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0);
        step(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(4);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0);
        idle(30);

        // Connect and disconnect on the same host in IDLE: connect ignored.
        step(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0);
        idle(2);

        // Disconnect and matching connected in the same cycle.
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(2);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 2'd0);
        idle(2);

        // Two failing runs then reset mid-WAIT.
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(30);
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(30);
        step(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(4);
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(2);

        // Randomized traffic with varying TOE responsiveness.
        p_conn = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) p_conn = $urandom_range(0, 3) * 4;  // percent
            r   = ($urandom_range(0, 499) == 0);
            c   = ($urandom_range(0, 3) == 0);
            ch  = HW'($urandom_range(0, NH - 1));
            d   = ($urandom_range(0, 15) == 0);
            dh  = HW'($urandom_range(0, NH - 1));
            cd  = ($urandom_range(0, 99) < p_conn);
            cdh = ($urandom_range(0, 1) == 0) ? m_ph : HW'($urandom_range(0, NH - 1));
            step(r, c, ch, d, dh, cd, cdh);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fix_conn_mgr.md
# fix_conn_mgr

Parametrised connection manager for the FIX engine. It sits between the application API and the TOE-facing FIFOs. It turns application connect/disconnect requests for any of NUM_HOSTS hosts into single-cycle TOE request pulses and tracks per-host link status. It adds timeout, bounded retry and failure reporting, which the single-host connect path does not have.

## Interface
Parameters:
- NUM_HOSTS, 4, number of remote hosts; must be ≥2.
- HOST_W, $clog2(NUM_HOSTS), width of host index fields.
- TIMEOUT_CYC, 64, cycles spent in WAIT per attempt; must be ≥2.
- MAX_RETRY, 3, re-requests after the first attempt; total attempts are 1+MAX_RETRY.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- connect_i  in  1  application connect request; sampled only when ready_o=1.
- connect_to_host_i  in  HOST_W  target host for connect_i.
- disconnect_i  in  1  application disconnect request; sampled every cycle.
- disconnect_host_i  in  HOST_W  target host for disconnect_i.
- connected_i  in  1  TOE connection-established pulse.
- connected_host_addr_i  in  HOST_W  host reported by connected_i.
- connect_req_o  out  1  one-cycle connect request to FIFO.
- connect_addr_o  out  HOST_W  host for connect_req_o; holds the pending host.
- disconnect_o  out  1  one-cycle disconnect request to FIFO.
- disconnect_host_num_o  out  HOST_W  host for disconnect_o.
- ready_o  out  1  high in IDLE; a new connect can be accepted.
- host_up_o  out  NUM_HOSTS  per-host connected flag.
- connect_fail_o  out  1  one-cycle pulse when all attempts are exhausted.
- fail_host_o  out  HOST_W  host that failed; valid with connect_fail_o.

## Operation
- FSM states: IDLE, REQ, WAIT, FAIL. All outputs are registered.
- Accepting a connect (IDLE, connect_i=1, host not up):
  - latch the host and clear retry_cnt;
  - go to REQ.
- Connect to a host whose host_up_o bit is already set: ignored; stay in IDLE.
- REQ: connect_req_o=1 for exactly one cycle, then go to WAIT with the timer cleared.
- WAIT: timer increments every cycle.
  - connected_i with connected_host_addr_i equal to the pending host: set host_up_o bit, go to IDLE.
  - No match when timer = TIMEOUT_CYC-1 and retry_cnt < MAX_RETRY: retry_cnt++, go to REQ.
  - No match when timer = TIMEOUT_CYC-1 and retry_cnt = MAX_RETRY: go to FAIL.
- A matching connected_i during REQ is also accepted: set the bit, go to IDLE.
- FAIL: connect_fail_o=1 and fail_host_o=pending host for one cycle, then go to IDLE.
- connected_i for a non-pending host, or in IDLE/FAIL: ignored.
- Disconnect (any state, disconnect_i=1):
  - next cycle: disconnect_o=1, disconnect_host_num_o=host;
  - the host_up_o bit clears on the same edge.
  - If the host equals the pending host in REQ/WAIT: abort to IDLE with no fail pulse and no further connect_req_o.

## Timing
- Reset values:
  - state=IDLE, ready_o=1;
  - host_up_o=0;
  - connect_req_o, disconnect_o and connect_fail_o = 0;
  - connect_addr_o, disconnect_host_num_o and fail_host_o = 0.
- Connect accepted at cycle t: connect_req_o high at t+1; WAIT occupies t+2 .. t+1+TIMEOUT_CYC.
- Consecutive connect_req_o pulses are spaced TIMEOUT_CYC+1 cycles apart.
- After the last attempt: connect_fail_o fires at the cycle following the final WAIT cycle, and ready_o returns 1 the cycle after that.
- A matching connected_i at cycle t:
  - host_up_o bit set at t+1;
  - ready_o=1 at t+1.
- Simultaneous events:
  - matching connected_i on the timeout cycle: the connect wins; no retry.
  - connect_i and disconnect_i on the same host in IDLE: the disconnect wins, and the connect is ignored.
  - connect_i and disconnect_i on different hosts: both are accepted.
  - disconnect_i and matching connected_i in the same cycle: the disconnect wins, and the bit ends cleared.
- Reset asserted mid-operation: returns to IDLE next edge; all outputs return to reset values; any pending pulse is dropped.

## Configuration
- FIX_CONN_STATS_EN defined adds two outputs:
  - retry_cnt_o[7:0]: saturating count of all retries (REQ entries beyond the first per request);
  - fail_cnt_o[7:0]: saturating count of FAIL entries.
  - Both reset to 0 and stick at 255.
- FIX_CONN_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
All scenarios use NUM_HOSTS=4, TIMEOUT_CYC=8, MAX_RETRY=2.
- Reset, then connect_i to host 2 at t=0, connected_i for host 2 at t=4 -> connect_req_o pulse at t=1 with addr 2; host_up_o=4'b0100 at t=5; ready_o=1 at t=5.
- Connect to host 1 with no connected_i -> connect_req_o at t=1, 10 and 19; connect_fail_o with fail_host_o=1 at t=28; ready_o=1 at t=29; host_up_o=0.
- Connect to host 3; matching connected_i at the timeout cycle t=9 -> no second connect_req_o; host_up_o[3]=1 at t=10.
- Host 0 up; disconnect_i host 0 together with connect_i host 1 -> disconnect_o with host 0 next cycle; host_up_o[0]=0; connect_req_o for host 1 next cycle.
- Connect to host 2, disconnect_i host 2 during WAIT -> disconnect_o pulse; return to IDLE; no connect_fail_o; no further connect_req_o.
- With FIX_CONN_STATS_EN, run the failing scenario twice -> retry_cnt_o=4, fail_cnt_o=2; rst mid-WAIT -> all outputs return to reset values next edge.
